br_commit_unit: RTL and testbench
=================================

// Module: br_commit_unit
// PURPOSE
//  Producer side of the branch predictor's EXMEM_* update/recovery interface.
//  - Captures per-instruction prediction metadata at IF.
//  - Carries it through ID and EX alongside the pipeline, with stall and flush.
//  - Resolves conditional-branch outcome in EX.
//  - Presents registered commit info from the MEM slot to the gshare predictor.
// PARAMETERS
//  INDEX_WIDTH    12  BTB index width; tag = pc[31:INDEX_WIDTH+2]
//  HISTORY_WIDTH   4  PHT index width; pht index = pc[HISTORY_WIDTH+1:2]
//  CNT_WIDTH      32  perf counter width (used only with BR_PERF_CNT_EN)
// PORTS
//  clk_i                  in   1    clock, rising edge
//  rst_i                  in   1    asynchronous, active-high reset
//  stall_i                in   1    hold IF/ID/EX slots, bubble into MEM
//  flush_i                in   1    predictor IF_flush_o: kill D and E slots
//  IF_valid_i             in   1    IF slot holds a real instruction
//  IF_pc_i                in   32   fetch PC
//  IF_btb_hit_i           in   1    predictor IF_btb_hit_o
//  IF_prediction_i        in   1    predictor IF_prediction_o
//  ID_is_br_i             in   1    D-slot instr is conditional branch
//  ID_is_uncbr_i          in   2    2'b10 JAL, 2'b11 JALR, else 2'b00
//  ID_funct3_i            in   3    D-slot branch funct3
//  EX_rs1_i, EX_rs2_i     in   32   E-slot operands (forwarded)
//  EX_target_i            in   32   E-slot computed branch/jump target
//  EXMEM_btb_wr_index_o   out  INDEX_WIDTH     M.pc[INDEX_WIDTH+1:2]
//  EXMEM_btb_wr_tag_o     out  30-INDEX_WIDTH  M.pc[31:INDEX_WIDTH+2]
//  EXMEM_btb_wr_target_o  out  32   M target
//  EXMEM_pht_wr_index_o   out  HISTORY_WIDTH   M.pc[HISTORY_WIDTH+1:2]
//  EXMEM_btb_hit_o        out  1    M btb_hit
//  EXMEM_br_decision_o    out  1    M resolved decision
//  EXMEM_is_br_o          out  1    M is conditional branch
//  EXMEM_is_uncbr_o       out  2    M unconditional kind
//  EXMEM_prediction_o     out  1    M prediction made at IF
//  EXMEM_pc_plus4_o       out  32   M.pc + 4 (mod 2^32)
//  perf_br_cnt_o          out  CNT_WIDTH  committed branch/jump count
//  perf_mispred_cnt_o     out  CNT_WIDTH  mispredict count
// BEHAVIOUR
//  - Three slots D, E, M; each holds a valid bit + metadata, all flops.
//  - Reset: all valid bits = 0, all metadata = 0.
//    => every EXMEM_* output = 0 and both counters = 0.
//  - Per-edge priority: rst_i > flush_i > stall_i > advance.
//  - flush_i: D <= bubble, E <= bubble, M <= bubble. The IF instr is wrong-path and is dropped.
//  - stall_i (no flush): D and E hold; M <= bubble. The IF instr is not captured.
//  - Advance:
//    - D <= {IF_valid_i, pc, btb_hit, prediction}
//    - E <= D + {ID_is_br_i, ID_is_uncbr_i, ID_funct3_i}
//    - M <= E + {decision, EX_target_i}
//  - Decision, computed in E:
//    - funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
//    - 010/011: decision = 0 and is_br forced 0.
//    - JAL/JALR: decision = 1.
//  - Bubble slot: is_br = 0, is_uncbr = 2'b00.
//  - Latency: IF capture -> EXMEM_* visible 3 edges later, absent stalls.
//  - Outputs are driven only from M flops (no combinational path from inputs).
//    - Invalid M drives all EXMEM_* = 0.
//  - ID_* and EX_* inputs are sampled only when their slot is valid and advancing.
//  - Back-to-back branches need no spacing; each commits for exactly one cycle.
//  - Reset mid-operation clears all slots immediately (asynchronous); no commit survives.
// CONFIGURATION
//  - BR_PERF_CNT_EN defined:
//    - On each edge with valid M and (is_br | is_uncbr==2'b10 | is_uncbr==2'b11):
//      - perf_br_cnt_o += 1.
//      - perf_mispred_cnt_o += 1 if is_uncbr==2'b11 or prediction != decision.
//    - Both counters saturate at all-ones.
//  - Undefined: counter logic is absent and both outputs are tied to 0.
// TESTING
//  1. Reset asserted mid-stream -> all EXMEM_* = 0 same cycle; counters = 0.
//  2. BEQ pc=0x100, rs1=rs2=5, pred=0
//     -> 3 edges later: is_br=1, decision=1, prediction=0, pc_plus4=0x104,
//        btb_wr_index=0x040, pht_wr_index=0x0.
//  3. BLT rs1=0xFFFFFFFF, rs2=1 -> decision=1; BLTU with the same operands -> decision=0.
//  4. flush_i pulsed while D and E hold branches -> neither appears at EXMEM_*;
//     the next IF instr commits 3 edges after flush.
//  5. stall_i high 2 cycles with a JAL in E -> M shows 2 bubbles, then JAL commits once
//     (is_uncbr=2'b10, decision=1).
//  6. BR_PERF_CNT_EN: 4 branches, 1 mispredicted, plus 1 JALR -> perf_br_cnt=5, perf_mispred_cnt=2.

Source files
------------

// File: rtl/br_commit_unit.sv
// br_commit_unit: carries branch-prediction metadata from IF through the D, E
// and M slots. It resolves conditional branches in E and presents registered
// commit information from the M slot to the gshare predictor.
// Optional feature macro: BR_PERF_CNT_EN enables the saturating counters for
// committed branches and mispredicts. When it is not defined, both counters
// are tied to zero.
module br_commit_unit #(
  parameter int INDEX_WIDTH   = 12,
  parameter int HISTORY_WIDTH = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     IF_valid_i,
  input  logic [31:0]              IF_pc_i,
  input  logic                     IF_btb_hit_i,
  input  logic                     IF_prediction_i,
  input  logic                     ID_is_br_i,
  input  logic [1:0]               ID_is_uncbr_i,
  input  logic [2:0]               ID_funct3_i,
  input  logic [31:0]              EX_rs1_i,
  input  logic [31:0]              EX_rs2_i,
  input  logic [31:0]              EX_target_i,
  output logic [INDEX_WIDTH-1:0]   EXMEM_btb_wr_index_o,
  output logic [29-INDEX_WIDTH:0]  EXMEM_btb_wr_tag_o,
  output logic [31:0]              EXMEM_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0] EXMEM_pht_wr_index_o,
  output logic                     EXMEM_btb_hit_o,
  output logic                     EXMEM_br_decision_o,
  output logic                     EXMEM_is_br_o,
  output logic [1:0]               EXMEM_is_uncbr_o,
  output logic                     EXMEM_prediction_o,
  output logic [31:0]              EXMEM_pc_plus4_o,
  output logic [CNT_WIDTH-1:0]     perf_br_cnt_o,
  output logic [CNT_WIDTH-1:0]     perf_mispred_cnt_o
);

  // D slot (p0), E slot (p1), M slot (p2)
  logic        vld_p0, vld_p1, vld_p2;
  logic [31:0] pc_p0, pc_p1;
  logic [31:2] pc_p2;
  logic        hit_p0, hit_p1, hit_p2;
  logic        pred_p0, pred_p1, pred_p2;
  logic        is_br_p1, is_br_p2;
  logic [1:0]  uncbr_p1, uncbr_p2;
  logic [2:0]  funct3_p1;
  logic [31:0] target_p2, pc4_p2;
  logic        dec_p2;

  logic        br_ex;
  logic        dec_ex;
  logic signed [31:0] rs1_s, rs2_s;

  assign rs1_s = EX_rs1_i;
  assign rs2_s = EX_rs2_i;

  function automatic logic resolve_branch(input logic [2:0] funct3,
                                          input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = (a < b);
      3'b101:  taken = (a >= b);
      3'b110:  taken = ($unsigned(a) < $unsigned(b));
      3'b111:  taken = ($unsigned(a) >= $unsigned(b));
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Resolve the E-slot decision; reserved funct3 (010/011) is not a branch
  always_comb begin
    br_ex  = is_br_p1 && (funct3_p1[2:1] != 2'b01);
    dec_ex = 1'b0;
    if (uncbr_p1[1])
      dec_ex = 1'b1;
    else if (br_ex)
      dec_ex = resolve_branch(funct3_p1, rs1_s, rs2_s);
  end

  // IF -> D: capture fetch metadata; flush drops the wrong-path instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      vld_p0  <= 1'b0;
      pc_p0   <= '0;
      hit_p0  <= 1'b0;
      pred_p0 <= 1'b0;
    end else if (!stall_i) begin
      vld_p0  <= IF_valid_i;
      pc_p0   <= IF_pc_i;
      hit_p0  <= IF_btb_hit_i;
      pred_p0 <= IF_prediction_i;
    end
  end

  // D -> E: add decode info, sampled only for a valid D slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      pc_p1     <= '0;
      hit_p1    <= 1'b0;
      pred_p1   <= 1'b0;
      is_br_p1  <= 1'b0;
      uncbr_p1  <= 2'b00;
      funct3_p1 <= 3'b000;
    end else if (flush_i || (!stall_i && !vld_p0)) begin
      vld_p1    <= 1'b0;
      pc_p1     <= '0;
      hit_p1    <= 1'b0;
      pred_p1   <= 1'b0;
      is_br_p1  <= 1'b0;
      uncbr_p1  <= 2'b00;
      funct3_p1 <= 3'b000;
    end else if (!stall_i) begin
      vld_p1    <= 1'b1;
      pc_p1     <= pc_p0;
      hit_p1    <= hit_p0;
      pred_p1   <= pred_p0;
      is_br_p1  <= ID_is_br_i;
      uncbr_p1  <= ID_is_uncbr_i;
      funct3_p1 <= ID_funct3_i;
    end
  end

  // E -> M: a bubble zeroes every field so the outputs read zero when M is empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2    <= 1'b0;
      pc_p2     <= '0;
      pc4_p2    <= '0;
      target_p2 <= '0;
      hit_p2    <= 1'b0;
      pred_p2   <= 1'b0;
      dec_p2    <= 1'b0;
      is_br_p2  <= 1'b0;
      uncbr_p2  <= 2'b00;
    end else if (flush_i || stall_i || !vld_p1) begin
      vld_p2    <= 1'b0;
      pc_p2     <= '0;
      pc4_p2    <= '0;
      target_p2 <= '0;
      hit_p2    <= 1'b0;
      pred_p2   <= 1'b0;
      dec_p2    <= 1'b0;
      is_br_p2  <= 1'b0;
      uncbr_p2  <= 2'b00;
    end else begin
      vld_p2    <= 1'b1;
      pc_p2     <= pc_p1[31:2];
      pc4_p2    <= pc_p1 + 32'd4;
      target_p2 <= EX_target_i;
      hit_p2    <= hit_p1;
      pred_p2   <= pred_p1;
      dec_p2    <= dec_ex;
      is_br_p2  <= br_ex;
      uncbr_p2  <= uncbr_p1;
    end
  end

  assign EXMEM_btb_wr_index_o  = pc_p2[INDEX_WIDTH+1:2];
  assign EXMEM_btb_wr_tag_o    = pc_p2[31:INDEX_WIDTH+2];
  assign EXMEM_btb_wr_target_o = target_p2;
  assign EXMEM_pht_wr_index_o  = pc_p2[HISTORY_WIDTH+1:2];
  assign EXMEM_btb_hit_o       = hit_p2;
  assign EXMEM_br_decision_o   = dec_p2;
  assign EXMEM_is_br_o         = is_br_p2;
  assign EXMEM_is_uncbr_o      = uncbr_p2;
  assign EXMEM_prediction_o    = pred_p2;
  assign EXMEM_pc_plus4_o      = pc4_p2;

`ifdef BR_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] br_cnt, mis_cnt;
  logic                 count_br, count_mis;

  assign count_br  = vld_p2 && (is_br_p2 || (uncbr_p2 == 2'b10) || (uncbr_p2 == 2'b11));
  assign count_mis = (uncbr_p2 == 2'b11) || (pred_p2 != dec_p2);

  // Saturating commit and mispredict counters driven by the M slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (count_br) begin
      if (br_cnt != CNT_MAX)
        br_cnt <= br_cnt + CNT_ONE;
      if (count_mis && (mis_cnt != CNT_MAX))
        mis_cnt <= mis_cnt + CNT_ONE;
    end
  end

  assign perf_br_cnt_o      = br_cnt;
  assign perf_mispred_cnt_o = mis_cnt;
`else
  logic unused_vld_p2;
  assign unused_vld_p2      = vld_p2;
  assign perf_br_cnt_o      = '0;
  assign perf_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_br_commit_unit.sv
// tb_br_commit_unit: scoreboard bench for br_commit_unit. It drives
// instructions through IF/ID/EX. Each instruction that will leave E is queued
// with its expected commit, and every cycle the M outputs are compared against
// the queue head, or against zero when no commit is due.
module tb_br_commit_unit;
  localparam int IW = 12;
  localparam int HW = 4;
  localparam int CW = 32;
  localparam int VW = IW + (30 - IW) + 32 + HW + 38;

  logic clk = 1'b0;
  logic rst;
  logic stall_i, flush_i;
  logic IF_valid_i, IF_btb_hit_i, IF_prediction_i;
  logic [31:0] IF_pc_i;
  logic ID_is_br_i;
  logic [1:0] ID_is_uncbr_i;
  logic [2:0] ID_funct3_i;
  logic [31:0] EX_rs1_i, EX_rs2_i, EX_target_i;
  logic [IW-1:0] idx_o;
  logic [29-IW:0] tag_o;
  logic [31:0] tgt_o, pc4_o;
  logic [HW-1:0] pht_o;
  logic hit_o, dec_o, isbr_o, pred_o;
  logic [1:0] uncbr_o;
  logic [CW-1:0] pbr_o, pmis_o;

  br_commit_unit #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall_i), .flush_i(flush_i),
    .IF_valid_i(IF_valid_i), .IF_pc_i(IF_pc_i), .IF_btb_hit_i(IF_btb_hit_i),
    .IF_prediction_i(IF_prediction_i), .ID_is_br_i(ID_is_br_i),
    .ID_is_uncbr_i(ID_is_uncbr_i), .ID_funct3_i(ID_funct3_i),
    .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_target_i(EX_target_i),
    .EXMEM_btb_wr_index_o(idx_o), .EXMEM_btb_wr_tag_o(tag_o),
    .EXMEM_btb_wr_target_o(tgt_o), .EXMEM_pht_wr_index_o(pht_o),
    .EXMEM_btb_hit_o(hit_o), .EXMEM_br_decision_o(dec_o),
    .EXMEM_is_br_o(isbr_o), .EXMEM_is_uncbr_o(uncbr_o),
    .EXMEM_prediction_o(pred_o), .EXMEM_pc_plus4_o(pc4_o),
    .perf_br_cnt_o(pbr_o), .perf_mispred_cnt_o(pmis_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic        is_br;
    logic [1:0]  uncbr;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] tgt;
  } instr_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [VW-1:0] vec;
    logic          br;
    logic          mis;
  } exp_t;

  exp_t   sb[$];
  instr_t d_s, e_s;
  instr_t nop;
  logic [31:0] cyc;
  int n_checks = 0;
  int n_pass = 0;
  int m_br = 0;
  int m_mis = 0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {idx_o, tag_o, tgt_o, pht_o, hit_o, dec_o, isbr_o, uncbr_o, pred_o, pc4_o};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  function automatic logic br_valid(instr_t i);
    return i.is_br && (i.f3 != 3'b010) && (i.f3 != 3'b011);
  endfunction

  function automatic logic ref_dec(instr_t i);
    if (i.uncbr == 2'b10 || i.uncbr == 2'b11) return 1'b1;
    if (!br_valid(i)) return 1'b0;
    case (i.f3)
      3'b000:  return i.rs1 == i.rs2;
      3'b001:  return i.rs1 != i.rs2;
      3'b100:  return $signed(i.rs1) < $signed(i.rs2);
      3'b101:  return $signed(i.rs1) >= $signed(i.rs2);
      3'b110:  return i.rs1 < i.rs2;
      default: return i.rs1 >= i.rs2;
    endcase
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic is_br, input logic [1:0] uncbr,
                                input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic pred, input logic hit, input logic [31:0] tgt);
    instr_t i;
    i.valid = 1'b1; i.pc = pc; i.hit = hit; i.pred = pred; i.is_br = is_br;
    i.uncbr = uncbr; i.f3 = f3; i.rs1 = rs1; i.rs2 = rs2; i.tgt = tgt;
    return i;
  endfunction

  function automatic exp_t expect_of(instr_t i, logic [31:0] when);
    exp_t e;
    logic [31:0] p4;
    logic d;
    d = ref_dec(i);
    p4 = i.pc + 32'd4;
    e.cyc = when;
    e.vec = {i.pc[IW+1:2], i.pc[31:IW+2], i.tgt, i.pc[HW+1:2], i.hit, d, br_valid(i), i.uncbr, i.pred, p4};
    e.br  = br_valid(i) || i.uncbr == 2'b10 || i.uncbr == 2'b11;
    e.mis = i.uncbr == 2'b11 || i.pred != d;
    return e;
  endfunction

  // One clock: drive at negedge, queue the E-slot commit, check after posedge
  task automatic step(input instr_t ifi, input logic stall, input logic flush);
    logic [31:0] r;
    exp_t e;
    @(negedge clk);
    r = $urandom;
    IF_valid_i = ifi.valid; IF_pc_i = ifi.pc; IF_btb_hit_i = ifi.hit; IF_prediction_i = ifi.pred;
    if (d_s.valid) begin
      ID_is_br_i = d_s.is_br; ID_is_uncbr_i = d_s.uncbr; ID_funct3_i = d_s.f3;
    end else begin
      ID_is_br_i = r[0]; ID_is_uncbr_i = r[2:1]; ID_funct3_i = r[5:3];
    end
    if (e_s.valid) begin
      EX_rs1_i = e_s.rs1; EX_rs2_i = e_s.rs2; EX_target_i = e_s.tgt;
    end else begin
      EX_rs1_i = $urandom; EX_rs2_i = $urandom; EX_target_i = $urandom;
    end
    stall_i = stall; flush_i = flush;
    if (!flush && !stall && e_s.valid) sb.push_back(expect_of(e_s, cyc + 1));
    if (flush) begin
      d_s = nop; e_s = nop;
    end else if (!stall) begin
      e_s = d_s; d_s = ifi;
    end
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check_eq("commit", dut_vec, e.vec);
      if (e.br) begin
        m_br++;
        if (e.mis) m_mis++;
      end
    end else begin
      check_eq("bubble", dut_vec, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(nop, 1'b0, 1'b0);
  endtask

  task automatic clear_model();
    d_s = nop; e_s = nop; sb.delete(); m_br = 0; m_mis = 0;
  endtask

  function automatic instr_t rand_instr();
    logic [31:0] r, a;
    instr_t i;
    r = $urandom;
    a = $urandom;
    i = mk({a[31:2], 2'b00}, 1'b0, 2'b00, r[2:0], $urandom, $urandom, r[3], r[4], $urandom);
    if (r[5]) i.rs2 = i.rs1;
    case (r[8:6])
      3'd0, 3'd1, 3'd2, 3'd3: i.is_br = 1'b1;
      3'd4: i.uncbr = 2'b10;
      3'd5: i.uncbr = 2'b11;
      default: i.is_br = 1'b0;
    endcase
    i.valid = (r[11:9] != 3'd0);
    return i;
  endfunction

  initial begin
    nop = '0;
    d_s = '0; e_s = '0; cyc = '0;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    IF_valid_i = 1'b0; IF_pc_i = '0; IF_btb_hit_i = 1'b0; IF_prediction_i = 1'b0;
    ID_is_br_i = 1'b0; ID_is_uncbr_i = 2'b00; ID_funct3_i = 3'b000;
    EX_rs1_i = '0; EX_rs2_i = '0; EX_target_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", dut_vec, '0);
    check_eq("reset_pbr", pbr_o, '0);
    check_eq("reset_pmis", pmis_o, '0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ pc=0x100, equal operands, predicted not taken
    step(mk(32'h100, 1'b1, 2'b00, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0, 32'h200), 1'b0, 1'b0);
    idle(2);
    check_eq("beq_isbr", isbr_o, 1);
    check_eq("beq_dec", dec_o, 1);
    check_eq("beq_pred", pred_o, 0);
    check_eq("beq_pc4", pc4_o, 32'h104);
    check_eq("beq_idx", idx_o, 12'h040);
    check_eq("beq_pht", pht_o, 4'h0);
    idle(1);

    // Signed vs unsigned compare on the same operands, then back-to-back mix
    step(mk(32'h1000, 1'b1, 2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h2000), 1'b0, 1'b0);
    step(mk(32'h1004, 1'b1, 2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'h2004), 1'b0, 1'b0);
    step(mk(32'h1008, 1'b1, 2'b00, 3'b001, 32'd7, 32'd7, 1'b1, 1'b1, 32'h2008), 1'b0, 1'b0);
    check_eq("blt_dec", dec_o, 1);
    step(mk(32'h100C, 1'b1, 2'b00, 3'b101, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'h200C), 1'b0, 1'b0);
    check_eq("bltu_dec", dec_o, 0);
    step(mk(32'h1010, 1'b1, 2'b00, 3'b111, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'h2010), 1'b0, 1'b0);
    step(mk(32'h1014, 1'b1, 2'b00, 3'b010, 32'd3, 32'd3, 1'b1, 1'b0, 32'h2014), 1'b0, 1'b0);
    step(mk(32'h1018, 1'b0, 2'b10, 3'b000, 32'd0, 32'd1, 1'b1, 1'b1, 32'h3000), 1'b0, 1'b0);
    step(mk(32'h101C, 1'b0, 2'b11, 3'b000, 32'd0, 32'd1, 1'b0, 1'b1, 32'h4000), 1'b0, 1'b0);
    step(mk(32'hFFFF_FFFC, 1'b0, 2'b00, 3'b000, 32'd9, 32'd9, 1'b0, 1'b0, 32'h5000), 1'b0, 1'b0);
    idle(3);

    // Flush while D and E hold branches; the IF instruction on that edge is dropped
    step(mk(32'h2000, 1'b1, 2'b00, 3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 32'h2100), 1'b0, 1'b0);
    step(mk(32'h2004, 1'b1, 2'b00, 3'b001, 32'd1, 32'd2, 1'b1, 1'b1, 32'h2104), 1'b0, 1'b0);
    step(mk(32'h2008, 1'b0, 2'b10, 3'b000, 32'd0, 32'd0, 1'b1, 1'b1, 32'h2108), 1'b0, 1'b1);
    step(mk(32'h3000, 1'b1, 2'b00, 3'b000, 32'd4, 32'd4, 1'b1, 1'b0, 32'h3100), 1'b0, 1'b0);
    idle(2);
    check_eq("flush_next", pc4_o, 32'h3004);
    idle(1);

    // Two stall cycles with a JAL in E
    step(mk(32'h4000, 1'b0, 2'b10, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1, 32'h4800), 1'b0, 1'b0);
    step(mk(32'h4004, 1'b1, 2'b00, 3'b100, 32'd1, 32'd2, 1'b1, 1'b0, 32'h4900), 1'b0, 1'b0);
    step(mk(32'h4008, 1'b1, 2'b00, 3'b110, 32'd2, 32'd1, 1'b0, 1'b0, 32'h4A00), 1'b1, 1'b0);
    step(mk(32'h4008, 1'b1, 2'b00, 3'b110, 32'd2, 32'd1, 1'b0, 1'b0, 32'h4A00), 1'b1, 1'b0);
    step(mk(32'h4008, 1'b1, 2'b00, 3'b110, 32'd2, 32'd1, 1'b0, 1'b0, 32'h4A00), 1'b0, 1'b0);
    check_eq("stall_jal_kind", uncbr_o, 2'b10);
    check_eq("stall_jal_dec", dec_o, 1);
    idle(3);

    // Random traffic with occasional stall and flush
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom;
      step(rand_instr(), (r[2:0] == 3'd0), (r[6:3] == 4'd0));
    end
    idle(3);
    check_eq("sb_drain", sb.size(), 0);
`ifdef BR_PERF_CNT_EN
    check_eq("rand_pbr", pbr_o, m_br);
    check_eq("rand_pmis", pmis_o, m_mis);
`endif

    // Reset asserted mid-cycle while a JAL is visible in M
    step(mk(32'h5000, 1'b0, 2'b10, 3'b000, 32'd0, 32'd0, 1'b1, 1'b1, 32'h5800), 1'b0, 1'b0);
    idle(2);
    check_eq("pre_rst_commit", uncbr_o, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_out", dut_vec, '0);
    check_eq("rst_async_pbr", pbr_o, '0);
    check_eq("rst_async_pmis", pmis_o, '0);
    @(negedge clk);
    rst = 1'b0;
    IF_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    clear_model();
    idle(3);

    // Counter scenario: four branches (one mispredicted) and one JALR
    step(mk(32'h6000, 1'b1, 2'b00, 3'b000, 32'd3, 32'd3, 1'b1, 1'b1, 32'h6100), 1'b0, 1'b0);
    step(mk(32'h6004, 1'b1, 2'b00, 3'b001, 32'd3, 32'd4, 1'b1, 1'b1, 32'h6104), 1'b0, 1'b0);
    step(mk(32'h6008, 1'b1, 2'b00, 3'b100, 32'd5, 32'd1, 1'b0, 1'b0, 32'h6108), 1'b0, 1'b0);
    step(mk(32'h600C, 1'b1, 2'b00, 3'b111, 32'd9, 32'd1, 1'b0, 1'b0, 32'h610C), 1'b0, 1'b0);
    step(mk(32'h6010, 1'b0, 2'b11, 3'b000, 32'd0, 32'd0, 1'b1, 1'b1, 32'h6110), 1'b0, 1'b0);
    idle(4);
`ifdef BR_PERF_CNT_EN
    check_eq("perf_br", pbr_o, 5);
    check_eq("perf_mis", pmis_o, 2);
`else
    check_eq("perf_br_off", pbr_o, 0);
    check_eq("perf_mis_off", pmis_o, 0);
`endif
    check_eq("final_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
